// File: rtl/debounce_pkg.sv
// Shared state encodings for the debounce/edge-detect block.
// Also imported by the bench to check the state register.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b11,
    S_WAIT_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/debounce_edge.sv
// Level debouncer with registered rise/fall pulses.
// dout changes once STABLE_N consecutive samples agree.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(STABLE_N);
  localparam logic [CW-1:0] LAST = CW'(STABLE_N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        S_LOW: begin
          dout <= 1'b0;
          cnt  <= din ? ONE : '0;
          if (din) state <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (!din) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= S_HIGH;
            cnt   <= '0;
            dout  <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_HIGH: begin
          dout <= 1'b1;
          cnt  <= !din ? ONE : '0;
          if (!din) state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (din) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= S_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          // corrupted encoding: drop quietly to a known low state
          state <= S_LOW;
          cnt   <= '0;
          dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with STABLE_N=4.
// Each scenario task checks outputs 1 time unit after the edge.
module tb_debounce_edge;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic dout, rise, fall;

  int tests  = 0;
  int errors = 0;

  debounce_edge #(.STABLE_N(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    tests++;
    if ((rise & fall) !== 1'b0) begin
      errors++;
      $display("FAIL both_pulses: rise=%b fall=%b required not both 1",
               rise, fall);
    end
  endtask

  task automatic expect3(input string name, input logic ed,
                         input logic er, input logic ef);
    tests++;
    if (dout !== ed || rise !== er || fall !== ef) begin
      errors++;
      $display("FAIL %s: dout/rise/fall=%b%b%b required %b%b%b",
               name, dout, rise, fall, ed, er, ef);
    end
  endtask

  task automatic expect_state(input string name, input state_t es);
    tests++;
    if (dut.state !== es) begin
      errors++;
      $display("FAIL %s: state=%b required %b", name, dut.state, es);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    tick();
    expect3("reset_edge1", 1'b0, 1'b0, 1'b0);
    expect_state("reset_state", S_LOW);
    tick();
    expect3("reset_edge2", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    din = 1'b0;
    tick();
    expect3("reset_release", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    din = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect3($sformatf("glitch_hi%0d", i), 1'b0, 1'b0, 1'b0);
    end
    din = 1'b0;
    tick();
    expect3("glitch_drop", 1'b0, 1'b0, 1'b0);
    expect_state("glitch_state", S_LOW);
  endtask

  task automatic test_rise();
    din = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 4)
        expect3($sformatf("rise_e%0d", i), 1'b0, 1'b0, 1'b0);
      else if (i == 4)
        expect3("rise_e4", 1'b1, 1'b1, 1'b0);
      else
        expect3($sformatf("rise_e%0d", i), 1'b1, 1'b0, 1'b0);
    end
    expect_state("rise_state", S_HIGH);
  endtask

  task automatic test_fall();
    din = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i < 4)
        expect3($sformatf("fall_e%0d", i), 1'b1, 1'b0, 1'b0);
      else if (i == 4)
        expect3("fall_e4", 1'b0, 1'b0, 1'b1);
      else
        expect3("fall_e5", 1'b0, 1'b0, 1'b0);
    end
    expect_state("fall_state", S_LOW);
  endtask

  task automatic test_abort_restart();
    logic [6:0] pat;
    pat = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      din = pat[i];
      tick();
      if (i < 6)
        expect3($sformatf("abort_e%0d", i + 1), 1'b0, 1'b0, 1'b0);
      else
        expect3("abort_e7", 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    pat = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      din = pat[i];
      tick();
      expect3($sformatf("b2b_abort%0d", i + 1), 1'b1, 1'b0, 1'b0);
    end
    expect_state("b2b_state", S_HIGH);
    din = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4)
        expect3($sformatf("b2b_fall%0d", i), 1'b1, 1'b0, 1'b0);
      else
        expect3("b2b_fall4", 1'b0, 1'b0, 1'b1);
    end
    tick();
    expect3("b2b_settle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    din = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect3($sformatf("rmid_e%0d", i), 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    expect3("rmid_rst", 1'b0, 1'b0, 1'b0);
    expect_state("rmid_state", S_LOW);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4)
        expect3($sformatf("rmid_post%0d", i), 1'b0, 1'b0, 1'b0);
      else
        expect3("rmid_post4", 1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_fall();
    test_abort_restart();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
